token_sink: RTL and testbench

TOKEN_SINK -- requirements
Module: token_sink

---
 rtl/token_sink.sv | 112 +++++++++++
 tb/tb_token_sink.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/token_sink.sv
// Ready/valid token sink: counts accepted tokens, tracks last payload and a 16-bit checksum,
// with optional LFSR backpressure. Define TOKEN_SINK_SEQ_CHECK_EN to compile in the sequence checker.
module token_sink #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned EXPECT_N  = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W:0]   sink_d,
  output logic              sink_r,
  input  logic              throttle_en,
  output logic              done,
  output logic [15:0]       count,
  output logic [DATA_W-1:0] last_data,
  output logic [15:0]       checksum,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [15:0]         count_q, count_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [15:0]         csum_q, csum_d;
  logic                xfer;
  logic                lfsr_fb;

  // Fibonacci taps 8,6,5,4 (bit indices 7,5,4,3), shifting toward the MSB.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    sink_r  = 1'b0;
    xfer    = 1'b0;
    state_d = state_q;
    lfsr_d  = lfsr_q;
    count_d = count_q;
    last_d  = last_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        sink_r = throttle_en ? lfsr_q[0] : 1'b1;
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        xfer   = sink_d[DATA_W] & sink_r;
        if (xfer) begin
          count_d = count_q + 16'd1;
          last_d  = sink_d[DATA_W-1:0];
          csum_d  = csum_q + 16'(sink_d[DATA_W-1:0]);
          if (count_q == 16'(EXPECT_N - 1)) state_d = DONE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      count_q <= '0;
      last_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
    end
  end

  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign last_data = last_q;
  assign checksum  = csum_q;

`ifdef TOKEN_SINK_SEQ_CHECK_EN
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              err_q, err_d;

  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (xfer) begin
      exp_d = exp_q + DATA_W'(1);
      if (sink_d[DATA_W-1:0] != exp_q) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_token_sink.sv
// Directed bench for token_sink: three instances (EXPECT_N = 1, 16, 256) share clock and reset.
module tb_token_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  sd  [3];
  logic        sr  [3];
  logic        te  [3];
  logic        dn  [3];
  logic [15:0] cnt [3];
  logic [15:0] cs  [3];
  logic [7:0]  ld  [3];
  logic        er  [3];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  ref_lfsr;
  logic [7:0]  pq[$];
  logic        exp_err;

  always #5 clk = ~clk;

  token_sink #(.DATA_W(8), .EXPECT_N(1), .LFSR_SEED(8'hA5)) u_n1 (
    .clk(clk), .reset(reset), .sink_d(sd[0]), .sink_r(sr[0]), .throttle_en(te[0]),
    .done(dn[0]), .count(cnt[0]), .last_data(ld[0]), .checksum(cs[0]), .err(er[0]));

  token_sink #(.DATA_W(8), .EXPECT_N(16), .LFSR_SEED(8'hA5)) u_n16 (
    .clk(clk), .reset(reset), .sink_d(sd[1]), .sink_r(sr[1]), .throttle_en(te[1]),
    .done(dn[1]), .count(cnt[1]), .last_data(ld[1]), .checksum(cs[1]), .err(er[1]));

  token_sink #(.DATA_W(8), .EXPECT_N(256), .LFSR_SEED(8'hA5)) u_n256 (
    .clk(clk), .reset(reset), .sink_d(sd[2]), .sink_r(sr[2]), .throttle_en(te[2]),
    .done(dn[2]), .count(cnt[2]), .last_data(ld[2]), .checksum(cs[2]), .err(er[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_tick;
    tick;
    ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  endtask

  // Leaves the DUT in IDLE (first cycle after release) and checks reset values.
  task automatic do_reset(input int idx);
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    check_eq("rst_sink_r",    32'(sr[idx]),  32'd0);
    check_eq("rst_done",      32'(dn[idx]),  32'd0);
    check_eq("rst_count",     32'(cnt[idx]), 32'd0);
    check_eq("rst_last_data", 32'(ld[idx]),  32'd0);
    check_eq("rst_checksum",  32'(cs[idx]),  32'd0);
    check_eq("rst_err",       32'(er[idx]),  32'd0);
  endtask

  task automatic enter_run;
    tick;
    ref_lfsr = 8'hA5;
  endtask

  task automatic stream(input int idx);
    int  i   = 0;
    int  cyc = 0;
    logic r;
    while (i < pq.size() && cyc < 4000) begin
      sd[idx] = {1'b1, pq[i]};
      #1;
      r = te[idx] ? ref_lfsr[0] : 1'b1;
      check_eq("sink_r", 32'(sr[idx]), 32'(r));
      run_tick;
      if (r) i++;
      cyc++;
    end
    sd[idx] = '0;
    check_eq("stream_budget", 32'(i), 32'(pq.size()));
  endtask

  task automatic fill_ramp(input int n);
    pq.delete();
    for (int k = 0; k < n; k++) pq.push_back(8'(k));
  endtask

  task automatic check_full16(input string pfx);
    check_eq({pfx, "_done"},      32'(dn[1]),  32'd1);
    check_eq({pfx, "_count"},     32'(cnt[1]), 32'd16);
    check_eq({pfx, "_checksum"},  32'(cs[1]),  32'd120);
    check_eq({pfx, "_last_data"}, 32'(ld[1]),  32'd15);
    check_eq({pfx, "_err"},       32'(er[1]),  32'd0);
    check_eq({pfx, "_sink_r"},    32'(sr[1]),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef TOKEN_SINK_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sd[k] = '0;
      te[k] = 1'b0;
    end

    // EXPECT_N=1, token held valid from reset release
    sd[0] = {1'b1, 8'h00};
    do_reset(0);
    tick;
    check_eq("n1_run_sink_r", 32'(sr[0]), 32'd1);
    tick;
    check_eq("n1_done",     32'(dn[0]),  32'd1);
    check_eq("n1_count",    32'(cnt[0]), 32'd1);
    check_eq("n1_checksum", 32'(cs[0]),  32'd0);
    check_eq("n1_sink_r",   32'(sr[0]),  32'd0);
    repeat (3) tick;
    check_eq("n1_hold_count", 32'(cnt[0]), 32'd1);
    check_eq("n1_hold_done",  32'(dn[0]),  32'd1);
    sd[0] = '0;

    // EXPECT_N=16 unthrottled, preceded by invalid cycles
    do_reset(1);
    enter_run;
    sd[1] = {1'b0, 8'h55};
    repeat (3) run_tick;
    check_eq("novalid_count",     32'(cnt[1]), 32'd0);
    check_eq("novalid_last_data", 32'(ld[1]),  32'd0);
    check_eq("novalid_checksum",  32'(cs[1]),  32'd0);
    fill_ramp(16);
    stream(1);
    check_full16("run16");
    sd[1] = {1'b1, 8'hAA};
    repeat (3) tick;
    check_full16("done_hold");
    sd[1] = '0;

    // Same stream with LFSR throttling
    te[1] = 1'b1;
    do_reset(1);
    enter_run;
    fill_ramp(16);
    stream(1);
    check_full16("thr16");
    te[1] = 1'b0;

    // Sequence checker: 0,1,2 in order, then 7 out of order
    do_reset(1);
    enter_run;
    fill_ramp(3);
    stream(1);
    check_eq("seq_err_before", 32'(er[1]), 32'd0);
    pq.delete();
    pq.push_back(8'h07);
    stream(1);
    check_eq("seq_err_after",  32'(er[1]),  32'(exp_err));
    check_eq("seq_count",      32'(cnt[1]), 32'd4);
    check_eq("seq_last_data",  32'(ld[1]),  32'd7);
    repeat (3) tick;
    check_eq("seq_err_sticky", 32'(er[1]),  32'(exp_err));
    check_eq("seq_not_done",   32'(dn[1]),  32'd0);

    // Reset after 5 transfers, with a valid token offered on the reset edge
    do_reset(1);
    enter_run;
    fill_ramp(5);
    stream(1);
    check_eq("mid_count5",    32'(cnt[1]), 32'd5);
    check_eq("mid_checksum5", 32'(cs[1]),  32'd10);
    sd[1] = {1'b1, 8'h05};
    reset = 1'b1;
    tick;
    check_eq("mid_rst_count",     32'(cnt[1]), 32'd0);
    check_eq("mid_rst_last_data", 32'(ld[1]),  32'd0);
    check_eq("mid_rst_checksum",  32'(cs[1]),  32'd0);
    check_eq("mid_rst_done",      32'(dn[1]),  32'd0);
    check_eq("mid_rst_sink_r",    32'(sr[1]),  32'd0);
    reset = 1'b0;
    sd[1] = '0;
    enter_run;
    fill_ramp(16);
    stream(1);
    check_full16("after_rst");

    // EXPECT_N=256: 255 x 0xFF + 0x01 = 65025 + 1 = 0xFE02
    do_reset(2);
    enter_run;
    pq.delete();
    for (int k = 0; k < 255; k++) pq.push_back(8'hFF);
    pq.push_back(8'h01);
    stream(2);
    check_eq("n256_checksum",  32'(cs[2]),  32'hFE02);
    check_eq("n256_count",     32'(cnt[2]), 32'd256);
    check_eq("n256_done",      32'(dn[2]),  32'd1);
    check_eq("n256_last_data", 32'(ld[2]),  32'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
